test_exit_responder: RTL and testbench
======================================

// Module: test_exit_responder
// PURPOSE
//  Bus responder at the test-exit address in ENV_TEST builds; receives the core's end-of-test store.
//  Completes each request with a one-cycle handshake and latches the first exit value.
//  Reports finished/success/timeout and a cycle count to the testbench top.
//  Sits behind the data-bus address decoder; the decoder routes only EXIT_ADDR-region requests here.
// PARAMETERS
//  ADDR_WIDTH      32      bus address width
//  DATA_WIDTH      32      bus data width (multiple of 8)
//  EXIT_ADDR       'h1000  word address of the exit register (= TEST_EXIT_ADDR)
//  WDATA_SUCCESS   1       exit value meaning pass (= TEST_WDATA_SUCCESS)
//  TIMEOUT_CYCLES  0       cycles before a forced timeout finish; 0 = disabled
// PORTS
//  clk         in   1             clock
//  rst         in   1             synchronous reset, active-high
//  bus_valid   in   1             request valid
//  bus_ready   out  1             request accepted when valid&ready
//  bus_addr    in   ADDR_WIDTH    byte address
//  bus_wen     in   1             1 = write, 0 = read
//  bus_wdata   in   DATA_WIDTH    write data
//  bus_wmask   in   DATA_WIDTH/8  byte-lane write enables
//  bus_rvalid  out  1             response valid (reads and writes)
//  bus_rdata   out  DATA_WIDTH    read data
//  finished    out  1             sticky: test ended (exit write or timeout)
//  success     out  1             sticky: finished by exit value == WDATA_SUCCESS
//  timeout     out  1             sticky: finished by timeout
//  addr_err    out  1             sticky: accepted request with addr != EXIT_ADDR (word-aligned compare)
//  exit_code   out  DATA_WIDTH    exit register contents
//  cycles      out  64            cycles since reset, frozen when finished
// BEHAVIOUR
//  Reset: state=IDLE; bus_ready=1, bus_rvalid=0, bus_rdata=0; finished=success=timeout=addr_err=0;
//   exit_code=0; cycles=0. Reset mid-transaction drops the pending response; no rvalid follows.
//  FSM IDLE: bus_ready=1; on valid -> latch request, go RESP. RESP: bus_ready=0, bus_rvalid=1 for exactly
//   one cycle, then IDLE. Throughput: one request per 2 cycles; latency request->rvalid = 1 cycle.
//  Responder never stalls a response; rvalid asserted without back-pressure.
//  Address compare ignores low log2(DATA_WIDTH/8) bits. Mismatch: set addr_err, rdata=0, no state effect.
//  Read hit: bus_rdata = exit_code (pre-request value); rdata=0 on writes and on misses.
//  Write hit: bytes with wmask=1 update exit_code (effect visible the cycle rvalid is high).
//   Only wmask all-ones while !finished ends the test: finished=1, success=(wdata==WDATA_SUCCESS).
//   Partial-mask writes update bytes but do not finish.
//  After finished: exit_code, success, timeout frozen; further writes ignored but still get rvalid.
//  cycles: +1 per cycle while !finished; saturates at 2^64-1.
//  Timeout: if TIMEOUT_CYCLES!=0 and cycles reaches TIMEOUT_CYCLES-1 while !finished, next edge sets
//   finished=1, timeout=1, success=0. Exit write accepted the same cycle wins (timeout stays 0).
//  Outputs finished/success/timeout change only on the edge where rvalid rises (exit) or at timeout edge.
// TESTING
//  1 Reset, idle 10 cycles -> all flags 0, cycles=10, bus_ready=1.
//  2 Write 0x1000 wdata=1 wmask=F -> rvalid 1 cycle later, finished=1 success=1 exit_code=1, cycles freeze.
//  3 Write 0x1000 wdata=0x3 wmask=F -> finished=1 success=0 exit_code=3; later write 1 -> ignored, rvalid still given.
//  4 Write wmask=0x1 wdata=0xAB, then read 0x1000 -> finished=0, rdata=0x000000AB.
//  5 Read 0x1004 -> rvalid, rdata=0, addr_err=1, finished=0.
//  6 TIMEOUT_CYCLES=20, no writes -> finished=timeout=1 at cycle 20; exit write at cycle 19 -> success=1, timeout=0.

Source files
------------

// File: rtl/test_exit_responder.sv
// test_exit_responder: test-exit bus responder that latches the exit value and reports
// finished/success/timeout plus a cycle count.
module test_exit_responder #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] EXIT_ADDR      = 'h1000,
    parameter logic [DATA_WIDTH-1:0] WDATA_SUCCESS  = 1,
    parameter logic [63:0]           TIMEOUT_CYCLES = 64'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bus_valid,
    output logic                    bus_ready,
    input  logic [ADDR_WIDTH-1:0]   bus_addr,
    input  logic                    bus_wen,
    input  logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic [DATA_WIDTH/8-1:0] bus_wmask,
    output logic                    bus_rvalid,
    output logic [DATA_WIDTH-1:0]   bus_rdata,
    output logic                    finished,
    output logic                    success,
    output logic                    timeout,
    output logic                    addr_err,
    output logic [DATA_WIDTH-1:0]   exit_code,
    output logic [63:0]             cycles
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(NB - 1);

    typedef enum logic {IDLE, RESP} state_t;
    state_t r_state, w_state_next;

    logic                  r_finished, r_success, r_timeout, r_addr_err;
    logic [DATA_WIDTH-1:0] r_exit_code, r_rdata, w_exit_code_next;
    logic [63:0]           r_cycles;
    logic                  w_accept, w_hit, w_wr, w_exit, w_timeout;

    assign w_accept  = bus_valid && r_state == IDLE;
    // Byte offset within the word is ignored when matching the exit register.
    assign w_hit     = ((bus_addr ^ EXIT_ADDR) & ~LOW_MASK) == '0;
    assign w_wr      = w_accept && w_hit && bus_wen && !r_finished;
    assign w_exit    = w_wr && &bus_wmask;
    // An exit write accepted on the same edge takes priority over the timeout.
    assign w_timeout = TIMEOUT_CYCLES != 64'd0 && !r_finished && !w_exit
                       && r_cycles == TIMEOUT_CYCLES - 64'd1;

    always_comb begin
        w_exit_code_next = r_exit_code;
        for (int i = 0; i < NB; i++)
            if (w_wr && bus_wmask[i]) w_exit_code_next[8*i +: 8] = bus_wdata[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = (r_state == IDLE && bus_valid) ? RESP : IDLE;
    end

    always_comb begin
        bus_ready  = r_state == IDLE;
        bus_rvalid = r_state == RESP;
        bus_rdata  = r_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata     <= '0;
            r_finished  <= 1'b0;
            r_success   <= 1'b0;
            r_timeout   <= 1'b0;
            r_addr_err  <= 1'b0;
            r_exit_code <= '0;
            r_cycles    <= '0;
        end else begin
            if (w_accept) r_rdata <= (w_hit && !bus_wen) ? r_exit_code : '0;
            if (w_accept && !w_hit) r_addr_err <= 1'b1;
            r_exit_code <= w_exit_code_next;
            if (!r_finished && r_cycles != '1) r_cycles <= r_cycles + 64'd1;
            if (w_exit) begin
                r_finished <= 1'b1;
                r_success  <= bus_wdata == WDATA_SUCCESS;
            end else if (w_timeout) begin
                r_finished <= 1'b1;
                r_timeout  <= 1'b1;
            end
        end
    end

    assign finished  = r_finished;
    assign success   = r_success;
    assign timeout   = r_timeout;
    assign addr_err  = r_addr_err;
    assign exit_code = r_exit_code;
    assign cycles    = r_cycles;
endmodule

// File: tb/tb_test_exit_responder.sv
// tb_test_exit_responder: scoreboard bench; expected read data is queued at issue and
// popped by a monitor whenever the responder presents rvalid.
module tb_test_exit_responder;
    logic        clk = 1'b0;
    logic        rst, bus_valid, bus_ready, bus_wen, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata, exit_code;
    logic [3:0]  bus_wmask;
    logic        finished, success, timeout, addr_err;
    logic [63:0] cycles;

    logic        t_rst, t_valid, t_ready, t_wen, t_rvalid;
    logic [31:0] t_addr, t_wdata, t_rdata, t_exit_code;
    logic [3:0]  t_wmask;
    logic        t_finished, t_success, t_timeout, t_addr_err;
    logic [63:0] t_cycles;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    test_exit_responder dut (
        .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .finished(finished), .success(success),
        .timeout(timeout), .addr_err(addr_err), .exit_code(exit_code), .cycles(cycles)
    );

    test_exit_responder #(.TIMEOUT_CYCLES(64'd20)) dut_to (
        .clk(clk), .rst(t_rst), .bus_valid(t_valid), .bus_ready(t_ready),
        .bus_addr(t_addr), .bus_wen(t_wen), .bus_wdata(t_wdata), .bus_wmask(t_wmask),
        .bus_rvalid(t_rvalid), .bus_rdata(t_rdata), .finished(t_finished), .success(t_success),
        .timeout(t_timeout), .addr_err(t_addr_err), .exit_code(t_exit_code), .cycles(t_cycles)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus_rvalid) begin
            if (exp_q.size() == 0) chk("unexpected_rvalid", 1, 0);
            else chk("rdata", {32'd0, bus_rdata}, {32'd0, exp_q.pop_front()});
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic req(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                       input logic [3:0] wmask, input logic [31:0] exp_rdata);
        @(negedge clk);
        bus_valid = 1'b1; bus_addr = addr; bus_wen = wen; bus_wdata = wdata; bus_wmask = wmask;
        exp_q.push_back(exp_rdata);
        @(negedge clk);
        bus_valid = 1'b0;
        chk("rvalid_latency", bus_rvalid, 1);
        chk("ready_in_resp", bus_ready, 0);
        @(negedge clk);
        chk("rvalid_one_cycle", bus_rvalid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; bus_valid = 1'b0; bus_addr = '0; bus_wen = 1'b0; bus_wdata = '0; bus_wmask = '0;
        t_rst = 1'b1; t_valid = 1'b0; t_addr = 32'h1000; t_wen = 1'b1; t_wdata = 32'd1; t_wmask = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", bus_ready, 1);
        chk("rst_rvalid", bus_rvalid, 0);
        chk("rst_rdata", bus_rdata, 0);
        chk("rst_flags", {finished, success, timeout, addr_err}, 0);
        chk("rst_exit_code", exit_code, 0);
        // Test 1: idle for 10 cycles after reset
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("t1_cycles", cycles, 10);
        chk("t1_flags", {finished, success, timeout, addr_err}, 0);
        chk("t1_ready", bus_ready, 1);
        // Test 2: passing exit write freezes the cycle counter
        do_reset();
        req(32'h1000, 1'b1, 32'd1, 4'hF, 32'd0);
        chk("t2_flags", {finished, success, timeout, addr_err}, 4'b1100);
        chk("t2_exit_code", exit_code, 1);
        repeat (5) @(negedge clk);
        chk("t2_cycles_frozen", cycles, 2);
        // Test 3: failing exit, then ignored writes
        do_reset();
        req(32'h1000, 1'b1, 32'd3, 4'hF, 32'd0);
        chk("t3_flags", {finished, success, timeout}, 3'b100);
        chk("t3_exit_code", exit_code, 3);
        req(32'h1000, 1'b1, 32'd1, 4'hF, 32'd0);
        chk("t3_post_success", success, 0);
        chk("t3_post_exit_code", exit_code, 3);
        req(32'h1000, 1'b0, 32'd0, 4'h0, 32'd3);
        // Test 4: partial writes merge bytes without finishing
        do_reset();
        req(32'h1000, 1'b1, 32'h000000AB, 4'h1, 32'd0);
        chk("t4_finished", finished, 0);
        req(32'h1000, 1'b0, 32'd0, 4'h0, 32'h000000AB);
        req(32'h1000, 1'b1, 32'h1234CD99, 4'h2, 32'd0);
        chk("t4_merge", exit_code, 32'h0000CDAB);
        chk("t4_finished2", finished, 0);
        // Test 5: in-word offset hits; next word and other regions miss
        req(32'h1002, 1'b0, 32'd0, 4'h0, 32'h0000CDAB);
        chk("t5_hit_no_err", addr_err, 0);
        req(32'h1004, 1'b0, 32'd0, 4'h0, 32'd0);
        chk("t5_addr_err", addr_err, 1);
        chk("t5_finished", finished, 0);
        req(32'h2000, 1'b1, 32'd1, 4'hF, 32'd0);
        chk("t5_miss_write_finished", finished, 0);
        chk("t5_miss_write_code", exit_code, 32'h0000CDAB);
        // Reset on the accepting edge drops the response
        @(negedge clk);
        bus_valid = 1'b1; bus_addr = 32'h1000; bus_wen = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_drops_rvalid", bus_rvalid, 0);
        bus_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("rst_drops_rvalid2", bus_rvalid, 0);
        // Test 6a: timeout instance with no writes
        t_rst = 1'b0;
        repeat (19) @(negedge clk);
        chk("t6_before_timeout", {t_finished, t_timeout}, 0);
        chk("t6_cycles19", t_cycles, 19);
        @(negedge clk);
        chk("t6_timeout_flags", {t_finished, t_success, t_timeout}, 3'b101);
        chk("t6_cycles20", t_cycles, 20);
        repeat (3) @(negedge clk);
        chk("t6_cycles_frozen", t_cycles, 20);
        // Test 6b: exit write accepted on the timeout edge wins
        t_rst = 1'b1;
        @(negedge clk);
        t_rst = 1'b0;
        repeat (19) @(negedge clk);
        t_valid = 1'b1;
        @(negedge clk);
        t_valid = 1'b0;
        chk("t6b_rvalid", t_rvalid, 1);
        chk("t6b_flags", {t_finished, t_success, t_timeout}, 3'b110);
        chk("t6b_cycles", t_cycles, 20);
        repeat (2) @(negedge clk);
        chk("t6b_flags_hold", {t_finished, t_success, t_timeout}, 3'b110);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
